// File: rtl/fpu_issue_unit.sv
// Issue front end of the FP co-processor: 16x32 register file, per-register
// scoreboard, in-flight limiter and a host-driven drain FSM.
module fpu_issue_unit #(
   parameter int MAX_INFLIGHT = 4
) (
   input  logic        clk,
   input  logic        nreset,

   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [3:0]  instr_srcA,
   input  logic [3:0]  instr_srcB,
   input  logic [3:0]  instr_dest,

   output logic [31:0] opA,
   output logic [31:0] opB,
   output logic [3:0]  dest_in,
   output logic        new_instr,

   input  logic        wb_enable,
   input  logic [3:0]  wb_dest,
   input  logic [31:0] wb_result,

   input  logic        host_we,
   input  logic [3:0]  host_addr,
   input  logic [31:0] host_wdata,
   input  logic [3:0]  host_raddr,
   output logic [31:0] host_rdata,

   input  logic        flush_req,
   output logic        flush_done,

   output logic [15:0] busy_vec,
   output logic [2:0]  inflight,
   output logic        err
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t      r_state;
   logic [31:0] r_regs [16];
   logic [15:0] r_busy;
   logic [2:0]  r_inflight;
   logic [31:0] r_opA;
   logic [31:0] r_opB;
   logic [3:0]  r_destIn;
   logic        r_newInstr;
   logic        r_flushDone;
   logic        r_err;

   logic        w_wbHit;
   logic        w_wbSpurious;
   logic [15:0] w_wbMask;
   logic [15:0] w_busyEff;
   logic        w_capOk;
   logic        w_hazardFree;
   logic        w_issue;
   logic        w_hostOk;
   logic        w_hostIllegal;
   logic [15:0] w_issueMask;
   logic [31:0] w_srcAData;
   logic [31:0] w_srcBData;

   // A writeback only counts when it retires a register that is actually busy;
   // that retirement frees the register and a counter slot within the same cycle.
   assign w_wbHit       = wb_enable & r_busy[wb_dest];
   assign w_wbSpurious  = wb_enable & ~r_busy[wb_dest];
   assign w_wbMask      = w_wbHit ? (16'b1 << wb_dest) : 16'b0;
   assign w_busyEff     = r_busy & ~w_wbMask;
   assign w_capOk       = (r_inflight < 3'(MAX_INFLIGHT)) | w_wbHit;
   assign w_hazardFree  = ~w_busyEff[instr_srcA] & ~w_busyEff[instr_srcB]
                        & ~w_busyEff[instr_dest];

   // flush_req blocks issue combinationally so nothing slips in on the cycle it rises.
   assign instr_ready   = (r_state == ST_RUN) & ~flush_req & ~host_we
                        & w_capOk & w_hazardFree;
   assign w_issue       = instr_valid & instr_ready;
   assign w_issueMask   = w_issue ? (16'b1 << instr_dest) : 16'b0;

   assign w_hostOk      = host_we & ~r_busy[host_addr];
   assign w_hostIllegal = host_we & r_busy[host_addr];

   assign w_srcAData = (w_wbHit && (wb_dest == instr_srcA)) ? wb_result : r_regs[instr_srcA];
   assign w_srcBData = (w_wbHit && (wb_dest == instr_srcB)) ? wb_result : r_regs[instr_srcB];

   // Host writes only land on idle registers and writebacks only on busy ones,
   // so the two never target the same entry in one cycle.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < 16; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         if (w_wbHit) begin
            r_regs[wb_dest] <= wb_result;
         end
         if (w_hostOk) begin
            r_regs[host_addr] <= host_wdata;
         end
      end
   end

   // Scoreboard: the issue set is applied after the writeback clear, so a
   // same-cycle reissue to the retiring register keeps it busy.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_busy     <= '0;
         r_inflight <= '0;
         r_err      <= 1'b0;
      end else begin
         r_busy <= (r_busy & ~w_wbMask) | w_issueMask;
         case ({w_issue, w_wbHit})
            2'b10:   r_inflight <= r_inflight + 3'd1;
            2'b01:   r_inflight <= r_inflight - 3'd1;
            default: r_inflight <= r_inflight;
         endcase
         r_err <= r_err | w_wbSpurious | w_hostIllegal;
      end
   end

   // Operand and destination registers only move on issue, holding otherwise.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_opA      <= '0;
         r_opB      <= '0;
         r_destIn   <= '0;
         r_newInstr <= 1'b0;
      end else begin
         r_newInstr <= w_issue;
         if (w_issue) begin
            r_opA    <= w_srcAData;
            r_opB    <= w_srcBData;
            r_destIn <= instr_dest;
         end
      end
   end

   // Drain FSM: DONE is a single cycle whose registered pulse is flush_done.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state     <= ST_RUN;
         r_flushDone <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               r_flushDone <= 1'b0;
               if (flush_req) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if ((r_inflight == 3'd0) && !w_wbHit) begin
                  r_state     <= ST_DONE;
                  r_flushDone <= 1'b1;
               end else begin
                  r_flushDone <= 1'b0;
               end
            end
            ST_DONE: begin
               r_flushDone <= 1'b0;
               r_state     <= flush_req ? ST_DRAIN : ST_RUN;
            end
            default: begin
               r_flushDone <= 1'b0;
               r_state     <= ST_RUN;
            end
         endcase
      end
   end

   assign opA        = r_opA;
   assign opB        = r_opB;
   assign dest_in    = r_destIn;
   assign new_instr  = r_newInstr;
   assign flush_done = r_flushDone;
   assign busy_vec   = r_busy;
   assign inflight   = r_inflight;
   assign err        = r_err;
   assign host_rdata = r_regs[host_raddr];

endmodule

// File: tb/tb_fpu_issue_unit.sv
// Directed bench for fpu_issue_unit: a cycle-by-cycle vector table plus
// hand-written drain and mid-flight reset sequences.
module tb_fpu_issue_unit;

   logic        clk;
   logic        nreset;
   logic        instr_valid;
   logic        instr_ready;
   logic [3:0]  instr_srcA;
   logic [3:0]  instr_srcB;
   logic [3:0]  instr_dest;
   logic [31:0] opA;
   logic [31:0] opB;
   logic [3:0]  dest_in;
   logic        new_instr;
   logic        wb_enable;
   logic [3:0]  wb_dest;
   logic [31:0] wb_result;
   logic        host_we;
   logic [3:0]  host_addr;
   logic [31:0] host_wdata;
   logic [3:0]  host_raddr;
   logic [31:0] host_rdata;
   logic        flush_req;
   logic        flush_done;
   logic [15:0] busy_vec;
   logic [2:0]  inflight;
   logic        err;

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      string       name;
      logic        iv;
      logic [3:0]  sa;
      logic [3:0]  sb;
      logic [3:0]  d;
      logic        we;
      logic [3:0]  wd;
      logic [31:0] wr;
      logic        hwe;
      logic [3:0]  ha;
      logic [31:0] hw;
      logic [3:0]  hr;
      logic        eReady;
      logic        eNew;
      logic [31:0] eA;
      logic [31:0] eB;
      logic [3:0]  eDest;
      logic [15:0] eBusy;
      logic [2:0]  eInfl;
      logic        eErr;
      logic [31:0] eRdata;
   } vec_t;

   vec_t vecs [17];

   fpu_issue_unit #(.MAX_INFLIGHT(4)) dut (
      .clk         (clk),
      .nreset      (nreset),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_srcA  (instr_srcA),
      .instr_srcB  (instr_srcB),
      .instr_dest  (instr_dest),
      .opA         (opA),
      .opB         (opB),
      .dest_in     (dest_in),
      .new_instr   (new_instr),
      .wb_enable   (wb_enable),
      .wb_dest     (wb_dest),
      .wb_result   (wb_result),
      .host_we     (host_we),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_raddr  (host_raddr),
      .host_rdata  (host_rdata),
      .flush_req   (flush_req),
      .flush_done  (flush_done),
      .busy_vec    (busy_vec),
      .inflight    (inflight),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act !== exp) begin
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         passCount++;
      end
   endtask

   task automatic applyIdle();
      instr_valid = 1'b0;
      instr_srcA  = 4'd0;
      instr_srcB  = 4'd0;
      instr_dest  = 4'd0;
      wb_enable   = 1'b0;
      wb_dest     = 4'd0;
      wb_result   = 32'd0;
      host_we     = 1'b0;
      host_addr   = 4'd0;
      host_wdata  = 32'd0;
      host_raddr  = 4'd0;
      flush_req   = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v);
      instr_valid = v.iv;
      instr_srcA  = v.sa;
      instr_srcB  = v.sb;
      instr_dest  = v.d;
      wb_enable   = v.we;
      wb_dest     = v.wd;
      wb_result   = v.wr;
      host_we     = v.hwe;
      host_addr   = v.ha;
      host_wdata  = v.hw;
      host_raddr  = v.hr;
      flush_req   = 1'b0;
   endtask

   initial begin
      //           name         iv sa sb d   we wd wr             hwe ha  hw             hr   rdy new eA             eB             eDst eBusy     eInf eErr eRdata
      vecs[0]  = '{"preload1",  0, 0, 0, 0,  0, 0, 32'h0,         1, 1,  32'h40400000,  1,   0, 0, 32'h0,         32'h0,         0,  16'h0000, 0,   0, 32'h40400000};
      vecs[1]  = '{"preload2",  0, 0, 0, 0,  0, 0, 32'h0,         1, 2,  32'h3F800000,  2,   0, 0, 32'h0,         32'h0,         0,  16'h0000, 0,   0, 32'h3F800000};
      vecs[2]  = '{"issue123",  1, 1, 2, 3,  0, 0, 32'h0,         0, 0,  32'h0,         1,   1, 1, 32'h40400000,  32'h3F800000,  3,  16'h0008, 1,   0, 32'h40400000};
      vecs[3]  = '{"rawStall",  1, 3, 1, 8,  0, 0, 32'h0,         0, 0,  32'h0,         3,   0, 0, 32'h40400000,  32'h3F800000,  3,  16'h0008, 1,   0, 32'h0};
      vecs[4]  = '{"rawBypass", 1, 3, 1, 8,  1, 3, 32'h40800000,  0, 0,  32'h0,         3,   1, 1, 32'h40800000,  32'h40400000,  8,  16'h0100, 1,   0, 32'h40800000};
      vecs[5]  = '{"wb8",       0, 0, 0, 0,  1, 8, 32'h41000000,  0, 0,  32'h0,         8,   1, 0, 32'h40800000,  32'h40400000,  8,  16'h0000, 0,   0, 32'h41000000};
      vecs[6]  = '{"issue4",    1, 1, 2, 4,  0, 0, 32'h0,         0, 0,  32'h0,         1,   1, 1, 32'h40400000,  32'h3F800000,  4,  16'h0010, 1,   0, 32'h40400000};
      vecs[7]  = '{"issue5",    1, 1, 2, 5,  0, 0, 32'h0,         0, 0,  32'h0,         1,   1, 1, 32'h40400000,  32'h3F800000,  5,  16'h0030, 2,   0, 32'h40400000};
      vecs[8]  = '{"issue6",    1, 1, 2, 6,  0, 0, 32'h0,         0, 0,  32'h0,         1,   1, 1, 32'h40400000,  32'h3F800000,  6,  16'h0070, 3,   0, 32'h40400000};
      vecs[9]  = '{"issue7",    1, 1, 2, 7,  0, 0, 32'h0,         0, 0,  32'h0,         1,   1, 1, 32'h40400000,  32'h3F800000,  7,  16'h00F0, 4,   0, 32'h40400000};
      vecs[10] = '{"capStall",  1, 1, 2, 9,  0, 0, 32'h0,         0, 0,  32'h0,         1,   0, 0, 32'h40400000,  32'h3F800000,  7,  16'h00F0, 4,   0, 32'h40400000};
      vecs[11] = '{"capWb",     1, 1, 2, 9,  1, 4, 32'h40A00000,  0, 0,  32'h0,         4,   1, 1, 32'h40400000,  32'h3F800000,  9,  16'h02E0, 4,   0, 32'h40A00000};
      vecs[12] = '{"spurious",  0, 0, 0, 0,  1, 10, 32'hDEADBEEF, 0, 0,  32'h0,         10,  0, 0, 32'h40400000,  32'h3F800000,  9,  16'h02E0, 4,   1, 32'h0};
      vecs[13] = '{"hostBusy",  0, 0, 0, 0,  0, 0, 32'h0,         1, 5,  32'h12345678,  5,   0, 0, 32'h40400000,  32'h3F800000,  9,  16'h02E0, 4,   1, 32'h0};
      vecs[14] = '{"hostAndWb", 0, 0, 0, 0,  1, 5, 32'h40C00000,  1, 11, 32'hCAFEF00D,  11,  0, 0, 32'h40400000,  32'h3F800000,  9,  16'h02C0, 3,   1, 32'hCAFEF00D};
      vecs[15] = '{"rd5",       0, 0, 0, 0,  0, 0, 32'h0,         0, 0,  32'h0,         5,   1, 0, 32'h40400000,  32'h3F800000,  9,  16'h02C0, 3,   1, 32'h40C00000};
      vecs[16] = '{"wawSet",    1, 11, 5, 6, 1, 6, 32'h40E00000,  0, 0,  32'h0,         6,   1, 1, 32'hCAFEF00D,  32'h40C00000,  6,  16'h02C0, 3,   1, 32'h40E00000};

      applyIdle();
      nreset = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rstNewInstr", 32'(new_instr), 32'd0);
      checkOutput("rstOpA", opA, 32'd0);
      checkOutput("rstBusy", 32'(busy_vec), 32'd0);
      checkOutput("rstInflight", 32'(inflight), 32'd0);
      checkOutput("rstErr", 32'(err), 32'd0);
      checkOutput("rstFlushDone", 32'(flush_done), 32'd0);
      nreset = 1'b1;

      // Table: drive at negedge, check ready before the edge and state after it.
      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput({vecs[i].name, ".ready"}, 32'(instr_ready), 32'(vecs[i].eReady));
         @(posedge clk);
         #1;
         checkOutput({vecs[i].name, ".newInstr"}, 32'(new_instr), 32'(vecs[i].eNew));
         checkOutput({vecs[i].name, ".opA"}, opA, vecs[i].eA);
         checkOutput({vecs[i].name, ".opB"}, opB, vecs[i].eB);
         checkOutput({vecs[i].name, ".destIn"}, 32'(dest_in), 32'(vecs[i].eDest));
         checkOutput({vecs[i].name, ".busy"}, 32'(busy_vec), 32'(vecs[i].eBusy));
         checkOutput({vecs[i].name, ".inflight"}, 32'(inflight), 32'(vecs[i].eInfl));
         checkOutput({vecs[i].name, ".err"}, 32'(err), 32'(vecs[i].eErr));
         checkOutput({vecs[i].name, ".rdata"}, host_rdata, vecs[i].eRdata);
         @(negedge clk);
      end

      // Mid-flight reset with registers 6, 7 and 9 outstanding.
      applyIdle();
      host_raddr = 4'd6;
      #2;
      nreset = 1'b0;
      #1;
      checkOutput("midRst.newInstr", 32'(new_instr), 32'd0);
      checkOutput("midRst.opA", opA, 32'd0);
      checkOutput("midRst.opB", opB, 32'd0);
      checkOutput("midRst.destIn", 32'(dest_in), 32'd0);
      checkOutput("midRst.busy", 32'(busy_vec), 32'd0);
      checkOutput("midRst.inflight", 32'(inflight), 32'd0);
      checkOutput("midRst.err", 32'(err), 32'd0);
      checkOutput("midRst.rdata", host_rdata, 32'd0);
      @(negedge clk);
      nreset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("postRst.busy", 32'(busy_vec), 32'd0);
      @(negedge clk);
      wb_enable = 1'b1;
      wb_dest   = 4'd6;
      wb_result = 32'h11111111;
      @(posedge clk);
      #1;
      checkOutput("lateWb.err", 32'(err), 32'd1);
      checkOutput("lateWb.rdata", host_rdata, 32'd0);
      checkOutput("lateWb.inflight", 32'(inflight), 32'd0);

      // Drain with two operations outstanding, then a repeated request.
      @(negedge clk);
      applyIdle();
      instr_valid = 1'b1;
      instr_dest  = 4'd1;
      #1;
      checkOutput("drain.issue1Ready", 32'(instr_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      instr_dest = 4'd2;
      @(posedge clk);
      #1;
      checkOutput("drain.inflight2", 32'(inflight), 32'd2);
      checkOutput("drain.busy", 32'(busy_vec), 32'h0006);
      @(negedge clk);
      instr_dest = 4'd3;
      flush_req  = 1'b1;
      #1;
      checkOutput("drain.readyBlocked", 32'(instr_ready), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("drain.noIssue", 32'(new_instr), 32'd0);
      checkOutput("drain.done0", 32'(flush_done), 32'd0);
      @(negedge clk);
      wb_enable = 1'b1;
      wb_dest   = 4'd1;
      wb_result = 32'h3F000000;
      #1;
      checkOutput("drain.readyDrain", 32'(instr_ready), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("drain.inflight1", 32'(inflight), 32'd1);
      checkOutput("drain.done1", 32'(flush_done), 32'd0);
      @(negedge clk);
      wb_dest = 4'd2;
      @(posedge clk);
      #1;
      checkOutput("drain.inflight0", 32'(inflight), 32'd0);
      checkOutput("drain.done2", 32'(flush_done), 32'd0);
      @(negedge clk);
      wb_enable = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("drain.pulse", 32'(flush_done), 32'd1);
      @(negedge clk);
      @(posedge clk);
      #1;
      checkOutput("drain.pulseEnd", 32'(flush_done), 32'd0);
      @(negedge clk);
      flush_req = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("drain.pulseAgain", 32'(flush_done), 32'd1);
      @(negedge clk);
      #1;
      checkOutput("drain.readyInDone", 32'(instr_ready), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("drain.pulseAgainEnd", 32'(flush_done), 32'd0);
      @(negedge clk);
      #1;
      checkOutput("drain.readyRun", 32'(instr_ready), 32'd1);
      @(posedge clk);
      #1;
      checkOutput("drain.resumeIssue", 32'(new_instr), 32'd1);
      checkOutput("drain.resumeDest", 32'(dest_in), 32'd3);
      @(negedge clk);
      applyIdle();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
